// File: rtl/seq_detect_prog_fsm.sv
// Runtime-programmable serial sequence detector: pattern/length/overlap loaded by cfg_load,
// registered one-cycle match pulse. Define SEQ_DETECT_PROG_MATCH_CNT_EN for a saturating match counter.
module seq_detect_prog_fsm #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               a_valid,
  input  logic               a,
  output logic               detected,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] hist, hist_n, pat, pat_n, mask, shifted;
  logic [LEN_W-1:0]   fill, fill_n, len, len_n;
  logic [LEN_W:0]     fill_inc;
  logic               ovl, ovl_n, det_n, cnt_clr, len_ok, full, hit;

  // Only the low len bits of history take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
  end

  assign len_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(MAX_LEN));
  assign shifted  = {hist[MAX_LEN-2:0], a};
  assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
  assign full     = (fill_inc >= {1'b0, len});
  assign hit      = full && (((shifted ^ pat) & mask) == '0);

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    det_n   = 1'b0;
    cnt_clr = 1'b0;
    if (cfg_load) begin
      hist_n  = '0;
      fill_n  = '0;
      cnt_clr = len_ok;
      if (len_ok) begin
        pat_n   = cfg_pattern;
        len_n   = cfg_len;
        ovl_n   = cfg_overlap;
        state_n = FILL;
      end else begin
        len_n   = '0;
        state_n = IDLE;
      end
    end else if (a_valid && state != IDLE) begin
      hist_n = shifted;
      fill_n = full ? len : fill_inc[LEN_W-1:0];
      if (full) state_n = ARMED;
      if (hit) begin
        det_n = 1'b1;
        // Non-overlapping: the next match must be built from fresh bits only.
        if (!ovl) begin
          fill_n  = '0;
          state_n = FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hist     <= '0;
      fill     <= '0;
      pat      <= '0;
      len      <= '0;
      ovl      <= 1'b0;
      detected <= 1'b0;
    end else begin
      state    <= state_n;
      hist     <= hist_n;
      fill     <= fill_n;
      pat      <= pat_n;
      len      <= len_n;
      ovl      <= ovl_n;
      detected <= det_n;
    end
  end

  assign armed = (state == ARMED);

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)            cnt <= '0;
    else if (det_n && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end
  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog_fsm.sv
// Bench for seq_detect_prog_fsm: queue-based reference model checked every cycle,
// directed pattern streams with literal expectations, then randomized traffic.
module tb_seq_detect_prog_fsm;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               a_valid = 1'b0;
  logic               a = 1'b0;
  logic               detected, armed;
  logic [CNT_W-1:0]   match_cnt;

  seq_detect_prog_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .a_valid(a_valid), .a(a),
    .detected(detected), .armed(armed), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the bits accepted since the last (re)start, oldest first.
  int          q[$];
  int          m_len = 0;
  logic [7:0]  m_pat = '0;
  logic        m_ovl = 1'b0, m_cfg = 1'b0, m_det = 1'b0, m_arm = 1'b0, m_ok;
  int          m_cnt = 0;

  always @(posedge clk) begin
    m_det = 1'b0;
    if (rst) begin
      q.delete(); m_cfg = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0; m_cnt = 0;
    end else if (cfg_load) begin
      q.delete();
      if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
        m_cfg = 1'b1; m_len = int'(cfg_len); m_pat = cfg_pattern; m_ovl = cfg_overlap; m_cnt = 0;
      end else begin
        m_cfg = 1'b0; m_len = 0;
      end
    end else if (a_valid && m_cfg) begin
      q.push_back(int'(a));
      if (q.size() > m_len) void'(q.pop_front());
      if (q.size() == m_len) begin
        m_ok = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[i] != int'(m_pat[m_len-1-i])) m_ok = 1'b0;
        if (m_ok) begin
          m_det = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          if (!m_ovl) q.delete();
        end
      end
    end
    m_arm = m_cfg && (q.size() == m_len);
  end

  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic b);
    rst = 1'b0; cfg_load = 1'b0; a_valid = v; a = b;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  // a_valid is held high during the load to show the load wins.
  task automatic load(input int len, input logic [7:0] pat, input logic ovl);
    rst = 1'b0; cfg_load = 1'b1; cfg_len = LEN_W'(len); cfg_pattern = pat; cfg_overlap = ovl;
    a_valid = 1'b1; a = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; a_valid = 1'b0;
  endtask

  // bits[n-1] is sent first; dv[i]/av[i] are detected/armed right after bit i.
  task automatic feed(input logic [15:0] bits, input int n, output logic [15:0] dv, output logic [15:0] av);
    dv = '0; av = '0;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, bits[n-1-i]);
      dv[i] = detected; av[i] = armed;
    end
  endtask

  logic [15:0] dv, av;
  int pulses;

  initial begin
    fork
      forever @(negedge clk) if (chk_en) begin
        logic [CNT_W-1:0] exp_cnt;
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        exp_cnt = CNT_W'(m_cnt);
`else
        exp_cnt = '0;
`endif
        n_cmp++;
        if (detected !== m_det || armed !== m_arm || match_cnt !== exp_cnt) begin
          n_bad++;
          $display("FAIL model_cmp t=%0t detected=%b/%b armed=%b/%b match_cnt=%0d/%0d",
                   $time, detected, m_det, armed, m_arm, match_cnt, exp_cnt);
        end
      end
      begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_detected", int'(detected), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        tick(1'b1, 1'b1);
        chk("idle_ignores_bits", int'(detected), 0);

        load(6, 8'b0011_0011, 1'b1);
        feed(16'b1100110011, 10, dv, av);
        chk("p110011_ovl1", int'(dv), 'h220);
        chk("p110011_ovl1_armed6", int'(av[5]), 1);

        load(6, 8'b0011_0011, 1'b0);
        feed(16'b110011001100, 12, dv, av);
        chk("p110011_ovl0", int'(dv), 'h020);
        chk("p110011_ovl0_armed6", int'(av[5]), 0);
        chk("p110011_ovl0_armed12", int'(av[11]), 1);

        load(4, 8'b0000_1010, 1'b1);
        feed(16'b1010101, 7, dv, av);
        chk("p1010_ovl1", int'(dv), 'h28);

        load(4, 8'b0000_1010, 1'b0);
        feed(16'b1010101, 7, dv, av);
        chk("p1010_ovl0", int'(dv), 'h08);

        // Sparse valid: one pulse, one cycle wide.
        load(4, 8'b1111_1010, 1'b1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
          tick(1'b1, (i % 2) == 0);
          pulses += int'(detected);
          if (i == 3) chk("gap_pulse_after_4th", int'(detected), 1);
          repeat (3) begin tick(1'b0, 1'b1); pulses += int'(detected); end
        end
        chk("gap_pulse_count", pulses, 1);

        load(4, 8'h0F, 1'b1);
        feed(16'h1F, 5, dv, av);
        load(8, 8'hFF, 1'b1);
        feed(16'h1FF, 9, dv, av);
        chk("reload_ff", int'(dv), 'h180);

        load(0, 8'hFF, 1'b1);
        feed(16'hFF, 8, dv, av);
        chk("len0_no_pulse", int'(dv), 0);
        chk("len0_not_armed", int'(av), 0);

        load(4, 8'b0000_1010, 1'b0);
        feed(16'b101, 3, dv, av);
        rst = 1'b1; a_valid = 1'b1; a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0;
        chk("rst_mid_detected", int'(detected), 0);
        chk("rst_mid_armed", int'(armed), 0);
        chk("rst_mid_cnt", int'(match_cnt), 0);
        feed(16'b1010, 4, dv, av);
        chk("rst_then_idle", int'(dv), 0);

        for (int c = 0; c < 3000; c++) begin
          rst = ($urandom_range(0, 299) == 0);
          cfg_load = ($urandom_range(0, 39) == 0);
          if ($urandom_range(0, 9) == 0) cfg_len = LEN_W'($urandom_range(0, 15));
          else if ($urandom_range(0, 2) == 0) cfg_len = LEN_W'($urandom_range(5, 8));
          else cfg_len = LEN_W'($urandom_range(1, 4));
          cfg_pattern = 8'($urandom);
          cfg_overlap = 1'($urandom);
          a_valid = ($urandom_range(0, 3) != 0);
          a = 1'($urandom);
          @(posedge clk); #1;
        end
        rst = 1'b0; cfg_load = 1'b0; a_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
